// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg: shared FSM state encoding, pending-slot type and
// fixed widths for the two-port SDRAM arbiter.
package sdram_arbiter_pkg;

  localparam int PORT_COUNT = 2;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
  } slot_t;

endpackage

// File: rtl/sdram_arbiter_slot.sv
// sdram_arbiter_slot: one requester's pending slot. Captures a request pulse
// while the port is not busy, and drops it once the arbiter grants it.
module sdram_arbiter_slot
  import sdram_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              read_rq,
  input  logic              write_rq,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              clear,
  input  logic              in_flight,
  output slot_t             slot,
  output logic              busy
);

  slot_t slot_q;
  logic  load;

  // Pulses that land while the port is already busy are dropped so the
  // pending request is never overwritten.
  assign busy = slot_q.valid | in_flight;
  assign load = (read_rq | write_rq) & ~busy;
  assign slot = slot_q;

  // Slot register: load on an accepted pulse (write wins), clear on grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_q <= '0;
    end else if (load) begin
      slot_q.valid   <= 1'b1;
      slot_q.we      <= write_rq;
      slot_q.address <= address;
      slot_q.data    <= data;
    end else if (clear) begin
      slot_q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port front end for a single SDRAM controller.
// Port 0 is the N64 PI side, port 1 the USB/CPU DMA side. One transaction is
// outstanding at a time.
// Build option SDRAM_ARBITER_ROUND_ROBIN_EN: when defined, contested grants
// alternate between ports; when undefined port 0 always wins a contest.
//
// Handshake: a requester pulses read_rq/write_rq for one cycle with address
// and data valid in that cycle; it must wait for o_pN_ack (busy low) before
// pulsing again. Toward memory, the arbiter pulses read_rq/write_rq once and
// holds select/address/data until the controller answers with i_mem_ack.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_p0_read_rq,
  input  logic              i_p0_write_rq,
  input  logic [ADDR_W-1:0] i_p0_address,
  input  logic [DATA_W-1:0] i_p0_data,
  output logic              o_p0_ack,
  output logic [DATA_W-1:0] o_p0_data,
  output logic              o_p0_busy,
  input  logic              i_p1_read_rq,
  input  logic              i_p1_write_rq,
  input  logic [ADDR_W-1:0] i_p1_address,
  input  logic [DATA_W-1:0] i_p1_data,
  output logic              o_p1_ack,
  output logic [DATA_W-1:0] o_p1_data,
  output logic              o_p1_busy,
  output logic              o_mem_select,
  output logic              o_mem_read_rq,
  output logic              o_mem_write_rq,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_data,
  output state_t            o_fsm_state
);

  state_t                  state_q, state_d;
  slot_t                   slot0, slot1;
  logic [PORT_COUNT-1:0]   clear, in_flight, ack_q;
  logic                    grant_valid, grant_sel, contested_pick;
  logic                    grant_port_q, grant_we_q, mem_done;
  logic [ADDR_W-1:0]       mem_address_q;
  logic [DATA_W-1:0]       mem_data_q, p0_data_q, p1_data_q;

  assign in_flight[0] = (state_q != ST_IDLE) & ~grant_port_q;
  assign in_flight[1] = (state_q != ST_IDLE) &  grant_port_q;
  assign clear[0]     = grant_valid & ~grant_sel;
  assign clear[1]     = grant_valid &  grant_sel;
  assign mem_done     = (state_q == ST_WAIT_ACK) & i_mem_ack;

  sdram_arbiter_slot u_slot0 (
    .clk(i_clk), .reset_n(i_reset_n), .read_rq(i_p0_read_rq),
    .write_rq(i_p0_write_rq), .address(i_p0_address), .data(i_p0_data),
    .clear(clear[0]), .in_flight(in_flight[0]), .slot(slot0), .busy(o_p0_busy)
  );

  sdram_arbiter_slot u_slot1 (
    .clk(i_clk), .reset_n(i_reset_n), .read_rq(i_p1_read_rq),
    .write_rq(i_p1_write_rq), .address(i_p1_address), .data(i_p1_data),
    .clear(clear[1]), .in_flight(in_flight[1]), .slot(slot1), .busy(o_p1_busy)
  );

`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
  logic rr_ptr_q;
  // Pointer names the port preferred on the next contested grant.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)       rr_ptr_q <= 1'b0;
    else if (grant_valid) rr_ptr_q <= ~grant_sel;
  end
  assign contested_pick = rr_ptr_q;
`else
  assign contested_pick = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state and grant selection; a grant is only taken from IDLE.
  always_comb begin
    state_d     = state_q;
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (slot0.valid | slot1.valid) begin
          grant_valid = 1'b1;
          grant_sel   = (slot0.valid & slot1.valid) ? contested_pick : ~slot0.valid;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE:    state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: if (i_mem_ack) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Latch the granted request; these hold the memory bus until the next grant.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      grant_port_q  <= 1'b0;
      grant_we_q    <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
    end else if (grant_valid) begin
      grant_port_q  <= grant_sel;
      grant_we_q    <= grant_sel ? slot1.we      : slot0.we;
      mem_address_q <= grant_sel ? slot1.address : slot0.address;
      mem_data_q    <= grant_sel ? slot1.data    : slot0.data;
    end
  end

  // Completion: capture read data on the controller ack, pulse port ack next cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ack_q     <= '0;
      p0_data_q <= '0;
      p1_data_q <= '0;
    end else begin
      ack_q <= '0;
      if (mem_done) begin
        ack_q[grant_port_q] <= 1'b1;
        if (!grant_we_q) begin
          if (grant_port_q) p1_data_q <= i_mem_data;
          else              p0_data_q <= i_mem_data;
        end
      end
    end
  end

  assign o_mem_select   = (state_q != ST_IDLE);
  assign o_mem_read_rq  = (state_q == ST_ISSUE) & ~grant_we_q;
  assign o_mem_write_rq = (state_q == ST_ISSUE) &  grant_we_q;
  assign o_mem_address  = mem_address_q;
  assign o_mem_data     = mem_data_q;
  assign o_p0_ack       = ack_q[0];
  assign o_p1_ack       = ack_q[1];
  assign o_p0_data      = p0_data_q;
  assign o_p1_data      = p1_data_q;
  assign o_fsm_state    = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed and randomized checks of sdram_arbiter against a
// transaction-level model (pending requests, arrival cycles, grant policy).
module tb_sdram_arbiter;
  import sdram_arbiter_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_p0_read_rq = 1'b0, i_p0_write_rq = 1'b0;
  logic [31:0] i_p0_address = '0, i_p0_data = '0;
  logic        i_p1_read_rq = 1'b0, i_p1_write_rq = 1'b0;
  logic [31:0] i_p1_address = '0, i_p1_data = '0;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_data = '0;
  logic        o_p0_ack, o_p0_busy, o_p1_ack, o_p1_busy;
  logic [31:0] o_p0_data, o_p1_data, o_mem_address, o_mem_data;
  logic        o_mem_select, o_mem_read_rq, o_mem_write_rq;
  state_t      o_fsm_state;

  sdram_arbiter dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_p0_read_rq(i_p0_read_rq), .i_p0_write_rq(i_p0_write_rq),
    .i_p0_address(i_p0_address), .i_p0_data(i_p0_data),
    .o_p0_ack(o_p0_ack), .o_p0_data(o_p0_data), .o_p0_busy(o_p0_busy),
    .i_p1_read_rq(i_p1_read_rq), .i_p1_write_rq(i_p1_write_rq),
    .i_p1_address(i_p1_address), .i_p1_data(i_p1_data),
    .o_p1_ack(o_p1_ack), .o_p1_data(o_p1_data), .o_p1_busy(o_p1_busy),
    .o_mem_select(o_mem_select), .o_mem_read_rq(o_mem_read_rq),
    .o_mem_write_rq(o_mem_write_rq), .o_mem_address(o_mem_address),
    .o_mem_data(o_mem_data), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .o_fsm_state(o_fsm_state)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int rq_cnt = 0;
  int ack_cnt [2] = '{0, 0};
  always @(negedge i_clk) begin
    if (o_mem_read_rq || o_mem_write_rq) rq_cnt++;
    if (o_p0_ack) ack_cnt[0]++;
    if (o_p1_ack) ack_cnt[1]++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / model state ----------------
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q [$];
  logic [31:0] served_q [$];
  logic [31:0] exp_pdata [2] = '{32'h0, 32'h0};
  bit          pend_v [2] = '{0, 0};
  bit          pend_we [2];
  logic [31:0] pend_addr [2], pend_data [2];
  int          pend_arr [2];
  int          free_cycle = 0;
  int          last_ic = 0;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
  int          rr_next = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr_req();
    i_p0_read_rq = 1'b0; i_p0_write_rq = 1'b0; i_p0_address = '0; i_p0_data = '0;
    i_p1_read_rq = 1'b0; i_p1_write_rq = 1'b0; i_p1_address = '0; i_p1_data = '0;
  endtask

  task automatic set_req(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      i_p0_write_rq = we; i_p0_read_rq = !we; i_p0_address = a; i_p0_data = d;
    end else begin
      i_p1_write_rq = we; i_p1_read_rq = !we; i_p1_address = a; i_p1_data = d;
    end
  endtask

  // Drive a legal request this cycle and record it in the model.
  task automatic post(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
    set_req(p, we, a, d);
    pend_v[p] = 1'b1; pend_we[p] = we; pend_addr[p] = a; pend_data[p] = d; pend_arr[p] = cyc;
  endtask

  function automatic logic get_ack(input int p);
    return (p == 0) ? o_p0_ack : o_p1_ack;
  endfunction
  function automatic logic get_busy(input int p);
    return (p == 0) ? o_p0_busy : o_p1_busy;
  endfunction
  function automatic logic [31:0] get_data(input int p);
    return (p == 0) ? o_p0_data : o_p1_data;
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_p0_ack"},   32'(o_p0_ack), 32'd0);
    chk({tag, "_p1_ack"},   32'(o_p1_ack), 32'd0);
    chk({tag, "_p0_busy"},  32'(o_p0_busy), 32'd0);
    chk({tag, "_p1_busy"},  32'(o_p1_busy), 32'd0);
    chk({tag, "_p0_data"},  o_p0_data, 32'd0);
    chk({tag, "_p1_data"},  o_p1_data, 32'd0);
    chk({tag, "_select"},   32'(o_mem_select), 32'd0);
    chk({tag, "_read_rq"},  32'(o_mem_read_rq), 32'd0);
    chk({tag, "_write_rq"}, 32'(o_mem_write_rq), 32'd0);
    chk({tag, "_mem_addr"}, o_mem_address, 32'd0);
    chk({tag, "_mem_data"}, o_mem_data, 32'd0);
    chk({tag, "_state"},    32'(o_fsm_state), 32'(ST_IDLE));
  endtask

  // Play the memory controller for one transaction of port p.
  task automatic serve(input int p, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int delay, input logic [31:0] rdata, input bit stray, input bit viol,
                       output int ic, output int m);
    int k;
    k = 0;
    while (!(o_mem_read_rq || o_mem_write_rq) && k < 40) begin
      tick();
      k++;
    end
    chk("rq_seen", 32'(o_mem_read_rq | o_mem_write_rq), 32'd1);
    ic = cyc;
    chk("mem_write_rq", 32'(o_mem_write_rq), 32'(we));
    chk("mem_read_rq", 32'(o_mem_read_rq), 32'(!we));
    chk("select_issue", 32'(o_mem_select), 32'd1);
    chk("mem_address", o_mem_address, addr);
    if (we) chk("mem_data", o_mem_data, wdata);
    chk("busy_in_flight", 32'(get_busy(p)), 32'd1);
    if (stray) begin
      i_mem_ack = 1'b1; i_mem_data = 32'hBAD0_BAD0;
    end
    tick();
    i_mem_ack = 1'b0; i_mem_data = '0;
    for (int d = 1; d < delay; d++) begin
      chk("wait_no_rq", 32'(o_mem_read_rq | o_mem_write_rq), 32'd0);
      if (viol && d == 1) begin
        set_req(p, 1'b0, addr ^ 32'h4, $urandom);
        tick();
        clr_req();
      end else begin
        tick();
      end
    end
    chk("wait_select", 32'(o_mem_select), 32'd1);
    chk("hold_address", o_mem_address, addr);
    if (we) chk("hold_data", o_mem_data, wdata);
    m = cyc;
    i_mem_ack = 1'b1; i_mem_data = rdata;
    tick();
    i_mem_ack = 1'b0; i_mem_data = '0;
    if (!we) exp_pdata[p] = rdata;
    chk("ack_port", 32'(get_ack(p)), 32'd1);
    chk("ack_other", 32'(get_ack(1 - p)), 32'd0);
    chk("port_data", get_data(p), exp_pdata[p]);
    chk("other_data", get_data(1 - p), exp_pdata[1 - p]);
    chk("select_after_ack", 32'(o_mem_select), 32'd0);
    chk("busy_after_ack", 32'(get_busy(p)), 32'd0);
  endtask

  // Serve every pending request in the order the grant rules dictate.
  task automatic serve_pending(input int delay_in, input bit stray, input bit viol,
                               input logic [31:0] rdata_first);
    int g, w, ic, m, dly, n;
    bit e0, e1;
    logic [31:0] rd;
    n = 0;
    while (pend_v[0] || pend_v[1]) begin
      g = 1 << 30;
      for (int p = 0; p < 2; p++)
        if (pend_v[p] && pend_arr[p] + 1 < g) g = pend_arr[p] + 1;
      if (free_cycle > g) g = free_cycle;
      e0 = pend_v[0] && (pend_arr[0] + 1 <= g);
      e1 = pend_v[1] && (pend_arr[1] + 1 <= g);
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
      if (e0 && e1) w = rr_next;
      else          w = e0 ? 0 : 1;
      rr_next = 1 - w;
`else
      w = e0 ? 0 : (e1 ? 1 : 0);
`endif
      dly = (delay_in > 0) ? delay_in : int'($urandom_range(1, 5));
      rd  = (n == 0) ? rdata_first : $urandom;
      serve(w, pend_we[w], pend_addr[w], pend_data[w], dly, rd, stray && (n == 0),
            viol && (dly >= 2), ic, m);
      chk("issue_cycle", ic, g + 1);
      last_ic = ic;
      served_q.push_back(w);
      pend_v[w] = 1'b0;
      free_cycle = m + 1;
      n++;
    end
  endtask

  task automatic model_reset();
    exp_pdata = '{32'h0, 32'h0};
    pend_v = '{0, 0};
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
    rr_next = 0;
`endif
    free_cycle = cyc;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int t, k, a0, a1, r0, m1;
    bit q0, q1;
    int first, off;

    clr_req();
    i_reset_n = 1'b0;
    tick(); tick();
    check_quiet("reset");
    i_reset_n = 1'b1;
    model_reset();
    tick();

    // Stray controller ack while idle is ignored.
    i_mem_ack = 1'b1; i_mem_data = 32'h1111_2222;
    tick();
    i_mem_ack = 1'b0; i_mem_data = '0;
    chk("stray_idle_ack0", 32'(o_p0_ack), 32'd0);
    chk("stray_idle_ack1", 32'(o_p1_ack), 32'd0);
    chk("stray_idle_state", 32'(o_fsm_state), 32'(ST_IDLE));

    // Single read on port 0, controller ack at t+6, stray ack during ISSUE.
    t = cyc;
    post(0, 1'b0, 32'h0000_1000, 32'h0);
    tick(); clr_req();
    chk("t1_busy", 32'(o_p0_busy), 32'd1);
    serve_pending(4, 1'b1, 1'b0, 32'hDEADBEEF);
    chk("t1_issue", last_ic, t + 2);
    chk("t1_ack_cycle", cyc, t + 7);
    chk("t1_p0_data", o_p0_data, 32'hDEADBEEF);

    // Single write on port 1; its read-data register stays untouched.
    post(1, 1'b1, 32'h0000_0010, 32'h1234_5678);
    tick(); clr_req();
    serve_pending(3, 1'b0, 1'b0, 32'hFFFF_FFFF);
    chk("t2_p1_data", o_p1_data, 32'h0);

    // Read and write together on one port: the write goes out.
    post(1, 1'b1, 32'h0000_0044, 32'h0000_CAFE);
    i_p1_read_rq = 1'b1;
    tick(); clr_req();
    serve_pending(2, 1'b0, 1'b0, $urandom);

    // Four rounds of simultaneous reads from both ports.
    served_q.delete();
    for (int r = 0; r < 4; r++) begin
      post(0, 1'b0, 32'h100 + r, 32'h0);
      post(1, 1'b0, 32'h200 + r, 32'h0);
      tick(); clr_req();
      serve_pending(0, 1'b0, 1'b0, $urandom);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd1);
    end
    chk("rr_count", served_q.size(), exp_q.size());
    while (exp_q.size() > 0 && served_q.size() > 0)
      chk("rr_order", served_q.pop_front(), exp_q.pop_front());

    // Second pulse on a busy port is dropped; only the first address goes out.
    post(0, 1'b0, 32'h0000_00A0, 32'h0);
    tick(); clr_req();
    set_req(0, 1'b0, 32'h0000_00B0, 32'h0);
    tick(); clr_req();
    a0 = ack_cnt[0];
    r0 = rq_cnt;
    serve_pending(3, 1'b0, 1'b0, $urandom);
    repeat (4) tick();
    chk("busy_viol_acks", ack_cnt[0] - a0, 32'd1);
    chk("busy_viol_rqs", rq_cnt - r0, 32'd1);

    // Reset while waiting for the controller, then a late ack.
    set_req(1, 1'b0, 32'h0000_0300, 32'h0);
    tick(); clr_req();
    k = 0;
    while (!o_mem_read_rq && k < 10) begin tick(); k++; end
    tick();
    chk("t5_wait_state", 32'(o_fsm_state), 32'(ST_WAIT_ACK));
    a0 = ack_cnt[0]; a1 = ack_cnt[1];
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    i_mem_ack = 1'b1; i_mem_data = 32'h5555_5555;
    tick();
    i_mem_ack = 1'b0; i_mem_data = '0;
    model_reset();
    check_quiet("t5");
    repeat (3) tick();
    chk("t5_no_ack0", ack_cnt[0] - a0, 32'd0);
    chk("t5_no_ack1", ack_cnt[1] - a1, 32'd0);
    chk("t5_idle", 32'(o_fsm_state), 32'(ST_IDLE));

    // Back-to-back: port 0 re-requests in its own ack cycle.
    post(0, 1'b0, 32'h0000_2000, 32'h0);
    tick(); clr_req();
    serve_pending(3, 1'b0, 1'b0, $urandom);
    m1 = free_cycle - 1;
    post(0, 1'b0, 32'h0000_2004, 32'h0);
    tick(); clr_req();
    serve_pending(2, 1'b0, 1'b0, $urandom);
    chk("b2b_issue", last_ic, m1 + 3);

    // Port 0 served alone, then a contest: the winner depends on the grant policy.
    post(0, 1'b0, 32'h0000_3000, 32'h0);
    tick(); clr_req();
    serve_pending(0, 1'b0, 1'b0, $urandom);
    post(0, 1'b1, 32'h0000_3004, $urandom);
    post(1, 1'b1, 32'h0000_3008, $urandom);
    tick(); clr_req();
    serve_pending(0, 1'b0, 1'b0, $urandom);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) tick();
      q0 = ($urandom_range(0, 3) != 0);
      q1 = ($urandom_range(0, 3) != 0);
      if (!q0 && !q1) q0 = 1'b1;
      first = $urandom_range(0, 1);
      off   = $urandom_range(0, 1);
      if (q0 && q1 && off == 1) begin
        post(first, 1'(($urandom_range(0, 1))), $urandom, $urandom);
        tick(); clr_req();
        post(1 - first, 1'(($urandom_range(0, 1))), $urandom, $urandom);
        tick(); clr_req();
      end else begin
        if (q0) post(0, 1'(($urandom_range(0, 1))), $urandom, $urandom);
        if (q1) post(1, 1'(($urandom_range(0, 1))), $urandom, $urandom);
        tick(); clr_req();
      end
      serve_pending(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    // Nothing further should be issued once the model has drained.
    r0 = rq_cnt;
    repeat (6) tick();
    chk("final_no_rq", rq_cnt - r0, 32'd0);
    chk("final_idle", 32'(o_fsm_state), 32'(ST_IDLE));
    chk("final_select", 32'(o_mem_select), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
